lcd_bus_arbiter: RTL

Shared-bus controller for the HD44780-style character LCD on the calculator board. It owns the `rs`/`rw`/`en`/`dados` pins and enforces the power-up delay and the enable-pulse and post-write timing. It serves two byte-write requesters with round-robin arbitration: port 0 for the init/command sequencer, port 1 for the operand/result character writer. This lets the display FSMs issue bytes without running their own delay counters.

---
 rtl/lcd_bus_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_arbiter.sv
`timescale 1ns/1ps
// Two-port round-robin byte writer that owns the HD44780 pins and all of their timing.
// Latency: ack on the grant edge N, en high N+S..N+S+E, done at N+S+E+H+W (W long for clear/home).
// Backpressure: requesters hold req until ack; requests are only evaluated in IDLE, never dropped.
module lcd_bus_arbiter #(
    parameter int unsigned POWERUP_CYC   = 2250000,
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned EN_CYC        = 25,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned WAIT_CYC      = 2500,
    parameter int unsigned LONG_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] dados
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The counter only ever holds (parameter - 1), so clog2 of the largest parameter is enough.
    localparam int unsigned MAX_CYC = max_u(max_u(max_u(POWERUP_CYC, SETUP_CYC), max_u(EN_CYC, HOLD_CYC)),
                                            max_u(WAIT_CYC, LONG_WAIT_CYC));
    localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_lim;
    logic               w_cnt_done;
    logic               w_long;

    logic               r_rs;
    logic [7:0]         r_dados;
    logic               r_en;
    logic               r_busy;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_done0;
    logic               r_done1;
    logic               r_last;
    logic               r_owner;

    logic               w_rs_nxt;
    logic [7:0]         w_dados_nxt;
    logic               w_ack0_nxt;
    logic               w_ack1_nxt;
    logic               w_done0_nxt;
    logic               w_done1_nxt;
    logic               w_last_nxt;
    logic               w_owner_nxt;
    logic               w_sel;

    // Clear (0x01) and return-home (0x02/0x03) commands need the long execution wait.
    assign w_long     = ~r_rs && (r_dados[7:2] == 6'd0) && (r_dados != 8'd0);
    assign w_cnt_done = (r_cnt == w_lim);

    // Terminal count for the state currently being timed.
    always_comb begin
        w_lim = '0;
        case (r_state)
            ST_PWRUP: w_lim = CNT_W'(POWERUP_CYC - 1);
            ST_SETUP: w_lim = CNT_W'(SETUP_CYC - 1);
            ST_PULSE: w_lim = CNT_W'(EN_CYC - 1);
            ST_HOLD:  w_lim = CNT_W'(HOLD_CYC - 1);
            ST_WAIT:  w_lim = w_long ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
            default:  w_lim = '0;
        endcase
    end

    // Next state, arbitration and one-cycle pulse generation.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_rs_nxt    = r_rs;
        w_dados_nxt = r_dados;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_sel       = r_last;
        case (r_state)
            ST_PWRUP: if (w_cnt_done) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (req0 || req1) begin
                    // On a tie the port that did not win last time goes first.
                    w_sel       = (req0 && req1) ? ~r_last : req1;
                    w_state_nxt = ST_SETUP;
                    w_rs_nxt    = w_sel ? rs1 : rs0;
                    w_dados_nxt = w_sel ? data1 : data0;
                    w_ack0_nxt  = ~w_sel;
                    w_ack1_nxt  = w_sel;
                    w_last_nxt  = w_sel;
                    w_owner_nxt = w_sel;
                end
            end
            ST_SETUP: if (w_cnt_done) begin
                w_state_nxt = ST_PULSE;
                w_cnt_nxt   = '0;
            end
            ST_PULSE: if (w_cnt_done) begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = '0;
            end
            ST_HOLD: if (w_cnt_done) begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
            end
            ST_WAIT: if (w_cnt_done) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_done0_nxt = ~r_owner;
                w_done1_nxt = r_owner;
            end
            default: begin
                w_state_nxt = ST_PWRUP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered pin/handshake outputs; en and busy follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PWRUP;
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_dados <= 8'h00;
            r_en    <= 1'b0;
            r_busy  <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rs    <= w_rs_nxt;
            r_dados <= w_dados_nxt;
            r_en    <= (w_state_nxt == ST_PULSE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
            r_done0 <= w_done0_nxt;
            r_done1 <= w_done1_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign done0 = r_done0;
    assign done1 = r_done1;
    assign busy  = r_busy;
    assign rs    = r_rs;
    assign rw    = 1'b0;
    assign en    = r_en;
    assign dados = r_dados;

endmodule
